// File: rtl/pe_pkg.sv
// Shared types and constants for the PE controller slice.
// State encoding, default pipeline depth and datapath mode codes.
package pe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    FILL,
    CALC,
    DRAIN,
    FIN
  } pe_state_t;

  localparam int PIPE_DEPTH_DEF = 4;

  localparam logic [1:0] MODE_CONV = 2'd0;
  localparam logic [1:0] MODE_DW   = 2'd1;
  localparam logic [1:0] MODE_FC   = 2'd2;
  localparam logic [1:0] MODE_POOL = 2'd3;

  function automatic int cnt_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/pe_drain_counter.sv
// Loadable down-counter used to wait out the MAC pipeline.
// Load wins over decrement; it stops at zero.
import pe_pkg::*;

module pe_drain_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  assign zero = (cnt_q == '0);

  // Count down while enabled, reload on demand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && !zero) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/pe_controller.sv
// Sequencing FSM for one PE convolution datapath.
// Optional PE_CTRL_PERF_CNT_EN adds busy/stall cycle counters.
import pe_pkg::*;

module pe_controller #(
  parameter int F          = 2,
  parameter int S          = 2,
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        acum,
  input  logic [1:0]  mode,
  input  logic        ov0,
  input  logic        ov1,
  input  logic        ov2,
  input  logic        empty,
  input  logic        stall,
  output logic [1:0]  mode_q,
  output logic        en,
  output logic        en0,
  output logic        en1,
  output logic        en2,
  output logic        clr0,
  output logic        clr1,
  output logic        clr2,
  output logic        clrW,
  output logic        clr,
  output logic        ld,
  output logic        ctrl_en,
  output logic        en_all,
  output logic        done,
`ifdef PE_CTRL_PERF_CNT_EN
  output logic [15:0] busy_cycles,
  output logic [15:0] stall_cycles,
`endif
  output logic        busy
);

  localparam int DW = cnt_w(PIPE_DEPTH);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(PIPE_DEPTH - 1);

  pe_state_t state;
  logic      acum_q;
  logic      run;
  logic      calc_last;
  logic      drain_dec;
  logic      drain_zero;

  assign run       = (state == CALC) && !(stall || empty);
  assign calc_last = run && ov0 && ov1 && ov2;
  assign drain_dec = (state == DRAIN) && !stall;

  pe_drain_counter #(
    .W (DW)
  ) u_drain (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (calc_last),
    .load_val (DRAIN_INIT),
    .dec      (drain_dec),
    .zero     (drain_zero)
  );

  // Sequence the run and latch its configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mode_q <= '0;
      acum_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            acum_q <= acum;
            mode_q <= mode;
            state  <= INIT;
          end
        end
        INIT:  state <= FILL;
        FILL:  if (!empty) state <= CALC;
        CALC:  if (calc_last) state <= DRAIN;
        DRAIN: if (!stall && drain_zero) state <= FIN;
        FIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Decode datapath steps and clears from state and status.
  always_comb begin
    en      = 1'b0;
    en0     = 1'b0;
    en1     = 1'b0;
    en2     = 1'b0;
    clr0    = 1'b0;
    clr1    = 1'b0;
    clr2    = 1'b0;
    clrW    = 1'b0;
    clr     = 1'b0;
    ld      = 1'b0;
    ctrl_en = 1'b0;
    en_all  = 1'b0;
    done    = 1'b0;
    unique case (state)
      INIT: begin
        clr0 = 1'b1;
        clr1 = 1'b1;
        clr2 = 1'b1;
        clrW = 1'b1;
        clr  = 1'b1;
      end
      FILL: ctrl_en = 1'b1;
      CALC: begin
        ctrl_en = 1'b1;
        en_all  = stall | empty;
        en      = run;
        en0     = run;
        en1     = run & ov0;
        clr0    = run & ov0;
        en2     = run & ov0 & ov1;
        clr1    = run & ov0 & ov1;
        ld      = run & ov0 & ov1;
        clr2    = calc_last;
      end
      DRAIN: en_all = stall;
      FIN:   done = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef PE_CTRL_PERF_CNT_EN
  // Saturating activity counters, cleared at the start of each run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cycles  <= '0;
      stall_cycles <= '0;
    end else if (state == INIT) begin
      busy_cycles  <= '0;
      stall_cycles <= '0;
    end else begin
      if (busy && busy_cycles != 16'hFFFF)
        busy_cycles <= busy_cycles + 16'd1;
      if (en_all && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: doc/pe_controller.md
# pe_controller

Sequencing FSM for one processing element's convolution datapath. Takes a `start` command plus the run's mode, filter size and stride. It then drives the datapath's enables and clears so that each output is accumulated over the nested loops: filter element (inner), window position (middle) and filter (outer). It freezes the datapath on input-buffer starvation or output stall, drains the 4-stage multiply/accumulate pipeline, and reports completion. It sits beside the PE datapath inside the PE top level, and its outputs connect one-to-one to the datapath control pins.

## Interface
- `F`, 2: width of `filter_size`.
- `S`, 2: width of `stride`.
- `PIPE_DEPTH`, 4: cycles from the last `en` to the last `done`-qualified psum write.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a run; ignored unless in IDLE.
- `acum`  in  1  psum-accumulate run; latched at `start`.
- `mode`  in  2  datapath mode; latched at `start`, passed through as `mode_q`.
- `ov0`, `ov1`, `ov2`  in  1 each  terminal flags of the window-element, ifmap-window and filter counters.
- `empty`  in  1  ifmap or filter scratchpad is empty.
- `stall`  in  1  the output write controller cannot accept data.
- `mode_q`  out  2  latched mode.
- `en`, `en0`, `en1`, `en2`  out  1 each  datapath step enables.
- `clr0`, `clr1`, `clr2`, `clrW`, `clr`  out  1 each  datapath clears.
- `ld`  out  1  row-base register load.
- `ctrl_en`  out  1  enables the scratchpad read controllers.
- `en_all`  out  1  pipeline freeze (active high).
- `done`  out  1  marks the final output of the run.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, INIT, FILL, CALC, DRAIN, FIN.
- IDLE
  - All outputs are 0.
  - `start` latches `acum` and `mode`, then goes to INIT.
- INIT (1 cycle)
  - `clrW` = `clr0` = `clr1` = `clr2` = `clr` = 1.
  - Goes to FILL.
- FILL
  - `ctrl_en` = 1.
  - Goes to CALC the first cycle `empty` = 0.
- CALC
  - `ctrl_en` = 1 and `en_all` = `stall | empty`.
  - When `en_all` = 0: `en` = `en0` = 1.
  - If `ov0` is also set: `en1` = 1 and `clr0` = 1.
  - If `ov0 & ov1`: `clr1` = 1, `en2` = 1, `ld` = 1.
  - If `ov0 & ov1 & ov2`: `clr2` = 1 and the FSM goes to DRAIN.
  - When `en_all` = 1, every step enable and clear is 0 and the counter state holds.
- DRAIN
  - `en_all` = `stall`.
  - A drain counter loads `PIPE_DEPTH-1` on entry and decrements only while `stall` = 0.
  - At 0, goes to FIN.
- FIN (1 cycle)
  - `done` = 1, then goes to IDLE.
- Counter overflow flags are sampled only when `en0` would be asserted. A flag that is high while frozen is not acted on.

## Timing
- Step enables and clears are combinational decodes of state and status. The datapath registers them, so a step takes effect at the next edge.
- `start` to first `en`: 3 cycles minimum (IDLE→INIT→FILL→CALC), plus one cycle per cycle that `empty` stays high in FILL.
- Throughput: one `en0` per unfrozen CALC cycle.
- Last `en0` to `done`: `PIPE_DEPTH`+1 cycles with no stall.
- `empty` and `stall` asserted together: freeze, with no priority difference.
- `rst_n` low at any time clears the state to IDLE, the drain counter to 0, and `mode_q`/acum latch to 0. All outputs are 0 during reset, and no `done` is issued for an aborted run.
- `start` outside IDLE: ignored and not queued.

## Configuration
- `PE_CTRL_PERF_CNT_EN`
  - Defined: adds outputs `busy_cycles` (16) and `stall_cycles` (16).
    - `busy_cycles` counts cycles with `busy` high; `stall_cycles` counts cycles with CALC/DRAIN `en_all` high.
    - Both clear at INIT and saturate at 16'hFFFF.
  - Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package `pe_pkg`: state enum `pe_state_t`, `PIPE_DEPTH` default, and mode encodings (`MODE_*`).
- One sub-module, `pe_drain_counter`: a loadable down-counter with hold enable and a zero flag.

## Test plan
- Reset mid-CALC:
  - Stimulus: assert `rst_n`=0 while `en0`=1.
  - Required: all outputs 0 in the same cycle; after release, `busy`=0 and the next `start` sees INIT.
- Nominal run:
  - Stimulus: filter terminal every 2 elements, 3 windows, 2 filters, no stall.
  - Required: exactly 12 `en0` pulses, 6 `en1`, 2 `en2`, and `done` 5 cycles after the last `en0`.
- Starvation:
  - Stimulus: `empty`=1 for 4 cycles mid-CALC.
  - Required: `en_all`=1 and no `en0` for those 4 cycles, then resume with no lost or extra steps (12 `en0` total).
- Drain stall:
  - Stimulus: `stall`=1 for 3 cycles during DRAIN.
  - Required: `done` delayed by exactly 3 cycles.
- Start ignored:
  - Stimulus: `start` pulsed during CALC.
  - Required: no INIT and no change in the pulse counts.
- Perf counters:
  - Stimulus: the starvation scenario with `PE_CTRL_PERF_CNT_EN` defined.
  - Required: `stall_cycles`=4 at `done`.
